// File: rtl/sargantana_icache_replace_ctrl.sv
// Instruction-cache refill sequencer: picks a victim way on a miss, fetches the line
// from memory and issues a single one-hot way write, surviving flush/kill aborts.
module sargantana_icache_replace_ctrl #(
   parameter int ICACHE_N_WAY     = 4,
   parameter int ICACHE_IDX_WIDTH = 6
) (
   input  logic                            clk_i,
   input  logic                            rstn_i,
   input  logic                            miss_valid_i,
   output logic                            miss_ready_o,
   input  logic [ICACHE_IDX_WIDTH-1:0]     miss_idx_i,
   input  logic [ICACHE_N_WAY-1:0]         way_valid_i,
   output logic                            fill_req_o,
   input  logic                            fill_gnt_i,
   input  logic                            fill_valid_i,
   input  logic                            fill_error_i,
   input  logic                            flush_i,
   input  logic                            kill_i,
   output logic [ICACHE_N_WAY-1:0]         way_we_o,
   output logic [ICACHE_IDX_WIDTH-1:0]     write_idx_o,
   output logic [$clog2(ICACHE_N_WAY)-1:0] victim_way_o,
   output logic                            busy_o,
   output logic                            error_o
);

   localparam int WAY_W = $clog2(ICACHE_N_WAY);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DRAIN,
      S_WRITE
   } state_t;

   state_t                      r_state;
   logic [WAY_W-1:0]            r_rrPtr;
   logic [WAY_W-1:0]            r_victim;
   logic [ICACHE_IDX_WIDTH-1:0] r_writeIdx;
   logic                        r_useRr;
   logic                        r_error;

   logic                        w_abort;
   logic                        w_accept;
   logic                        w_anyFree;
   logic [WAY_W-1:0]            w_freeVictim;
   logic [ICACHE_N_WAY-1:0]     w_wayWe;

   assign w_abort   = flush_i | kill_i;
   assign w_anyFree = ~&way_valid_i;
   assign w_accept  = miss_valid_i & miss_ready_o;

   // Scanning downwards leaves the lowest-index invalid way as the final pick.
   always_comb begin
      w_freeVictim = '0;
      for (int i = ICACHE_N_WAY - 1; i >= 0; i--) begin
         if (!way_valid_i[i]) begin
            w_freeVictim = WAY_W'(i);
         end
      end
   end

   always_comb begin
      w_wayWe = '0;
      for (int i = 0; i < ICACHE_N_WAY; i++) begin
         w_wayWe[i] = (r_state == S_WRITE) && !flush_i && (r_victim == WAY_W'(i));
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state    <= S_IDLE;
         r_rrPtr    <= '0;
         r_victim   <= '0;
         r_writeIdx <= '0;
         r_useRr    <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_error <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_victim   <= w_anyFree ? w_freeVictim : r_rrPtr;
                  r_useRr    <= ~w_anyFree;
                  r_writeIdx <= miss_idx_i;
                  r_state    <= S_REQ;
               end
            end
            // A grant that coincides with an abort still leaves a response in flight.
            S_REQ: begin
               if (fill_gnt_i) begin
                  r_state <= w_abort ? S_DRAIN : S_WAIT;
               end else if (w_abort) begin
                  r_state <= S_IDLE;
               end
            end
            S_WAIT: begin
               if (fill_valid_i) begin
                  if (w_abort) begin
                     r_state <= S_IDLE;
                  end else if (fill_error_i) begin
                     r_error <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_state <= S_WRITE;
                  end
               end else if (w_abort) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (fill_valid_i) begin
                  r_state <= S_IDLE;
               end
            end
            // The pointer moves only when a round-robin victim was actually written.
            S_WRITE: begin
               if (r_useRr && !flush_i) begin
                  r_rrPtr <= r_rrPtr + 1'b1;
               end
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign miss_ready_o = rstn_i & (r_state == S_IDLE) & ~w_abort;
   assign fill_req_o   = (r_state == S_REQ);
   assign busy_o       = (r_state != S_IDLE);
   assign way_we_o     = w_wayWe;
   assign write_idx_o  = r_writeIdx;
   assign victim_way_o = r_victim;
   assign error_o      = r_error;

endmodule
